// File: rtl/mem_wb_skid_stage.sv
// MEM/WB boundary register with valid/ready handshake and a 2-entry skid buffer.
// in_ready depends only on registered state, so back-pressure never forms a combinational path.
module mem_wb_skid_stage #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 32,
   parameter int REG_IDX_WIDTH = 5,
   parameter int SRC_WIDTH     = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    ALUResultM,
   input  logic [DATA_WIDTH-1:0]    ReadDataM,
   input  logic [ADDR_WIDTH-1:0]    PCPlus4M,
   input  logic [REG_IDX_WIDTH-1:0] RdM,
   input  logic                     RegWriteM,
   input  logic [SRC_WIDTH-1:0]     ResultSrcM,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResultW,
   output logic [DATA_WIDTH-1:0]    ReadDataW,
   output logic [ADDR_WIDTH-1:0]    PCPlus4W,
   output logic [REG_IDX_WIDTH-1:0] RdW,
   output logic                     RegWriteW,
   output logic [SRC_WIDTH-1:0]     ResultSrcW,
   output logic [1:0]               occupancy
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0]    alu;
      logic [DATA_WIDTH-1:0]    rdata;
      logic [ADDR_WIDTH-1:0]    pc4;
      logic [REG_IDX_WIDTH-1:0] rd;
      logic                     regwrite;
      logic [SRC_WIDTH-1:0]     src;
   } entry_t;

   entry_t in_ent;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   accept, drain;

   assign in_ent = '{alu: ALUResultM, rdata: ReadDataM, pc4: PCPlus4M,
                     rd: RdM, regwrite: RegWriteM, src: ResultSrcM};

   assign in_ready = ~skid_valid_q & rst_n;
   assign accept   = in_valid & in_ready;
   assign drain    = main_valid_q & out_ready;

   // Payload registers only load alongside their slot so idle slots keep their last value.
   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_d       = in_ent;
            main_valid_d = 1'b1;
         end
      end else if (drain) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d = in_ent;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = in_ent;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid  = main_valid_q;
   assign occupancy  = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   assign ALUResultW = main_q.alu;
   assign ReadDataW  = main_q.rdata;
   assign PCPlus4W   = main_q.pc4;
   assign RdW        = main_q.rd;
   assign ResultSrcW = main_q.src;
   // A bubble must never write the register file, whatever stale payload it holds.
   assign RegWriteW  = main_q.regwrite & main_valid_q;

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Bench for mem_wb_skid_stage: directed vector table, then random traffic against a queue model.
module tb_mem_wb_skid_stage;
   localparam int DW = 32, AW = 32, RW = 5, SW = 2;

   logic          clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DW-1:0] ALUResultM, ReadDataM, ALUResultW, ReadDataW;
   logic [AW-1:0] PCPlus4M, PCPlus4W;
   logic [RW-1:0] RdM, RdW;
   logic          RegWriteM, RegWriteW;
   logic [SW-1:0] ResultSrcM, ResultSrcW;
   logic [1:0]    occupancy;

   mem_wb_skid_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_IDX_WIDTH(RW), .SRC_WIDTH(SW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .ALUResultM(ALUResultM), .ReadDataM(ReadDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .out_valid(out_valid), .out_ready(out_ready),
      .ALUResultW(ALUResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W), .RdW(RdW),
      .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .occupancy(occupancy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0, checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the stage is a FIFO of at most two entries; W outputs show the
   // most recent entry to reach the head, which persists after it drains or is flushed.
   typedef struct packed {
      logic [DW-1:0] alu;
      logic [DW-1:0] rdata;
      logic [AW-1:0] pc4;
      logic [RW-1:0] rd;
      logic          rw;
      logic [SW-1:0] src;
   } ent_t;

   ent_t q[$];
   ent_t last;

   task automatic model_step();
      ent_t cur;
      int   sz;
      bit   acc;
      cur = '{alu: ALUResultM, rdata: ReadDataM, pc4: PCPlus4M, rd: RdM, rw: RegWriteM, src: ResultSrcM};
      if (!rst_n) begin
         q.delete();
         last = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         sz  = q.size();
         acc = in_valid && (sz < 2);
         if (sz > 0 && out_ready) void'(q.pop_front());
         if (acc) q.push_back(cur);
         if (q.size() > 0) last = q[0];
      end
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string nm);
      bit ov;
      ov = (q.size() > 0);
      chk({nm, ".out_valid"}, out_valid, ov);
      chk({nm, ".occupancy"}, occupancy, q.size());
      chk({nm, ".in_ready"}, in_ready, rst_n && (q.size() < 2));
      chk({nm, ".ALUResultW"}, ALUResultW, last.alu);
      chk({nm, ".ReadDataW"}, ReadDataW, last.rdata);
      chk({nm, ".PCPlus4W"}, PCPlus4W, last.pc4);
      chk({nm, ".RdW"}, RdW, last.rd);
      chk({nm, ".ResultSrcW"}, ResultSrcW, last.src);
      chk({nm, ".RegWriteW"}, RegWriteW, ov && last.rw);
   endtask

   typedef struct {
      logic          rst_n, flush, iv, ordy;
      logic [DW-1:0] alu;
      logic          rw;
      logic          e_ov;
      logic [DW-1:0] e_alu;
      logic [1:0]    e_occ;
      logic          e_ir, e_rww;
   } vec_t;

   vec_t vecs[21];

   initial begin
      int   drained, sent, n;
      logic [AW-1:0] next_pc, exp_pc;
      logic ir_a;
      vec_t v;

      //          rst flush iv ordy alu    rw | ov  alu    occ ir rww
      vecs[0]  = '{0, 0, 0, 0, 'h00, 0,  0, 'h00, 0, 0, 0};
      vecs[1]  = '{1, 0, 1, 1, 'h10, 1,  1, 'h10, 1, 1, 1};
      vecs[2]  = '{1, 0, 1, 1, 'h20, 1,  1, 'h20, 1, 1, 1};
      vecs[3]  = '{1, 0, 1, 1, 'h30, 0,  1, 'h30, 1, 1, 0};
      vecs[4]  = '{1, 0, 1, 1, 'h40, 1,  1, 'h40, 1, 1, 1};
      vecs[5]  = '{1, 0, 0, 1, 'h00, 0,  0, 'h40, 0, 1, 0};
      vecs[6]  = '{1, 0, 1, 0, 'h11, 1,  1, 'h11, 1, 1, 1};
      vecs[7]  = '{1, 0, 1, 0, 'h22, 0,  1, 'h11, 2, 0, 1};
      vecs[8]  = '{1, 0, 1, 1, 'h33, 1,  1, 'h22, 1, 1, 0};
      vecs[9]  = '{1, 0, 0, 1, 'h00, 0,  0, 'h22, 0, 1, 0};
      vecs[10] = '{1, 0, 1, 0, 'h44, 1,  1, 'h44, 1, 1, 1};
      vecs[11] = '{1, 0, 1, 0, 'h55, 1,  1, 'h44, 2, 0, 1};
      vecs[12] = '{1, 1, 1, 0, 'h66, 1,  0, 'h44, 0, 1, 0};
      vecs[13] = '{1, 0, 0, 1, 'h00, 0,  0, 'h44, 0, 1, 0};
      vecs[14] = '{1, 0, 1, 0, 'h65, 1,  1, 'h65, 1, 1, 1};
      vecs[15] = '{1, 0, 0, 0, 'h00, 0,  1, 'h65, 1, 1, 1};
      vecs[16] = '{1, 0, 0, 1, 'h00, 0,  0, 'h65, 0, 1, 0};
      vecs[17] = '{1, 0, 1, 0, 'h88, 1,  1, 'h88, 1, 1, 1};
      vecs[18] = '{1, 0, 1, 0, 'h99, 1,  1, 'h88, 2, 0, 1};
      vecs[19] = '{0, 0, 1, 1, 'hAA, 1,  0, 'h00, 0, 0, 0};
      vecs[20] = '{1, 0, 0, 0, 'h00, 0,  0, 'h00, 0, 1, 0};

      rst_n = 0; flush = 0; in_valid = 0; out_ready = 0;
      ALUResultM = '0; ReadDataM = '0; PCPlus4M = '0; RdM = '0; RegWriteM = 0; ResultSrcM = '0;
      last = '0;
      #1;

      // Directed table: RdM follows ALUResultM[4:0], so RdW should track the held ALU result.
      for (int i = 0; i < 21; i++) begin
         v = vecs[i];
         rst_n = v.rst_n; flush = v.flush; in_valid = v.iv; out_ready = v.ordy;
         ALUResultM = v.alu; ReadDataM = ~v.alu; PCPlus4M = v.alu + 4;
         RdM = v.alu[RW-1:0]; RegWriteM = v.rw; ResultSrcM = v.alu[SW-1:0];
         if (i == 19) chk("rst.in_ready_during", in_ready, 1'b0);
         cyc();
         chk($sformatf("vec%0d.out_valid", i), out_valid, v.e_ov);
         chk($sformatf("vec%0d.ALUResultW", i), ALUResultW, v.e_alu);
         chk($sformatf("vec%0d.occupancy", i), occupancy, v.e_occ);
         chk($sformatf("vec%0d.in_ready", i), in_ready, v.e_ir);
         chk($sformatf("vec%0d.RegWriteW", i), RegWriteW, v.e_rww);
         chk($sformatf("vec%0d.RdW", i), RdW, v.e_alu[RW-1:0]);
         if (i == 19) begin
            chk("rst.ReadDataW", ReadDataW, '0);
            chk("rst.PCPlus4W", PCPlus4W, '0);
            chk("rst.ResultSrcW", ResultSrcW, '0);
         end
      end

      // Random traffic: 1000 entries tagged by incrementing PC+4, drained in order.
      flush = 0; rst_n = 1;
      drained = 0; sent = 0; n = 0;
      next_pc = 'h1000; exp_pc = 'h1000;
      while (drained < 1000 && n < 8000) begin
         n++;
         in_valid   = (sent < 1000) ? 1'($urandom % 2) : 1'b0;
         out_ready  = 1'($urandom % 2);
         ALUResultM = $urandom; ReadDataM = $urandom; PCPlus4M = next_pc;
         RdM = RW'($urandom); RegWriteM = 1'($urandom); ResultSrcM = SW'($urandom);
         #1 ir_a = in_ready;
         out_ready = ~out_ready;
         #1 chk("comb.in_ready_vs_out_ready", in_ready, ir_a);
         out_ready = ~out_ready;
         #1;
         if (out_valid && out_ready) begin
            chk("sb.order_pc", PCPlus4W, exp_pc);
            exp_pc += 4;
            drained++;
         end
         if (in_valid && q.size() < 2) begin
            next_pc += 4;
            sent++;
         end
         cyc();
         check_model("rand");
      end
      chk("sb.drained_count", drained, 1000);
      chk("sb.sent_count", sent, 1000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
Parametrised MEM/WB pipeline boundary register with a valid/ready handshake and a 2-entry skid buffer. It sits between the memory stage and writeback. It supports back-pressure from writeback without a combinational ready path, a synchronous flush, and bubble-safe register-file write enables. It replaces the plain always-load MEM/WB register for the stall-capable pipeline.

Parameters:
DATA_WIDTH, 32, width of ALU result and load data
ADDR_WIDTH, 32, width of PC+4
REG_IDX_WIDTH, 5, destination register index width
SRC_WIDTH, 2, ResultSrc select width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous, active-low reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  MEM stage presents a valid entry
in_ready  out  1  stage can accept an entry this cycle
ALUResultM  in  DATA_WIDTH  ALU result
ReadDataM  in  DATA_WIDTH  load data
PCPlus4M  in  ADDR_WIDTH  PC+4
RdM  in  REG_IDX_WIDTH  destination register
RegWriteM  in  1  register write request
ResultSrcM  in  SRC_WIDTH  writeback mux select
out_valid  out  1  WB-side entry valid
out_ready  in  1  writeback consumes entry this cycle
ALUResultW  out  DATA_WIDTH  held ALU result
ReadDataW  out  DATA_WIDTH  held load data
PCPlus4W  out  ADDR_WIDTH  held PC+4
RdW  out  REG_IDX_WIDTH  held destination
RegWriteW  out  1  gated write enable
ResultSrcW  out  SRC_WIDTH  held select
occupancy  out  2  entries held (0..2)

Behaviour:
- Storage and handshake
  - Two slots: main (drives all W outputs) and skid. Each slot has its own valid bit.
  - Accept = in_valid & in_ready. Drain = out_valid & out_ready.
  - in_ready = ~skid_valid & rst_n. It is registered-state based, with no combinational path from out_ready. While rst_n is low, in_ready is 0.
  - out_valid = main_valid. occupancy = main_valid + skid_valid.
- Per-cycle update (no flush, rst_n high)
  - Main empty: an accepted entry loads main.
  - Main full, drain, skid empty: an accepted entry loads main. With no accept, main_valid clears.
  - Main full, drain, skid full: skid moves to main and skid_valid clears. No accept is possible.
  - Main full, no drain, accept: entry loads skid.
  - Main full, no drain, no accept: hold.
- Ordering and latency
  - Strict FIFO ordering is preserved.
  - Latency from accept to out_valid is 1 cycle when main is empty or draining, 2 cycles via skid otherwise.
  - Sustained throughput is 1 entry per cycle when out_ready is held 1.
- RegWriteW = main_RegWrite & main_valid. A bubble or flushed slot never asserts a write.
- Payload registers of an invalid or idle slot hold their last value. They load only when the slot loads.
- Flush
  - Next edge: main_valid = skid_valid = 0, and any same-cycle accept is discarded.
  - in_ready returns to 1 the following cycle.
  - Payload fields are not cleared.
  - Precedence: rst_n > flush > normal update.
- Reset (rst_n low at edge)
  - All slot valid bits 0.
  - All payload registers 0, so every W output is 0.
  - out_valid = 0, occupancy = 0.
  - Reset mid-transfer discards both slots.

Test Plan:
- Reset, then in_valid=1, out_ready=1, 4 entries ALUResultM=0x10,0x20,0x30,0x40 on consecutive cycles -> out_valid from cycle 1, W outputs 0x10..0x40 on consecutive cycles, occupancy stays 1, in_ready stays 1.
- Main holds A=0x11, out_ready=0, push B=0x22 -> occupancy=2, in_ready=0. Then out_ready=1 for 2 cycles -> A then B drained in order, in_ready=1 after the first drain.
- Flush with occupancy=2 and in_valid=1 carrying RegWriteM=1 -> next cycle out_valid=0, RegWriteW=0, occupancy=0. The flushed-cycle entry never appears.
- Entry with RegWriteM=1, RdM=5 accepted, then idle -> RegWriteW=1 for exactly the cycle(s) out_valid=1, and 0 once drained while RdW still reads 5.
- rst_n low for 1 cycle with occupancy=2 -> all W outputs 0, in_ready=0 during reset, in_ready=1 the cycle after.
- Random in_valid/out_ready (50%), 1000 entries with incrementing PCPlus4M -> scoreboard sees no loss, duplication or reordering, and in_ready never depends combinationally on out_ready.
